// File: rtl/ofm_read_controller_pkg.sv
// rtl/ofm_read_controller_pkg.sv - shared types and defaults for the OFM address controllers
//
// Purpose : state encodings and default geometry shared by the OFM buffer
//           address controllers.
// Contents: OFM_SIZE_DEF, ADDR_WIDTH_DEF, DATA_WIDTH_DEF, CNT_WIDTH,
//           ofm_rd_state_e (2-bit readout state encoding).
package ofm_read_controller_pkg;

  localparam int OFM_SIZE_DEF   = 32;
  localparam int ADDR_WIDTH_DEF = 14;
  localparam int DATA_WIDTH_DEF = 16;

  // Word counters are 20 bits: 127 channels * 32 * 32 words still fits.
  localparam int CNT_WIDTH = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ofm_rd_state_e;

endpackage

// File: rtl/ofm_rd_fifo.sv
// rtl/ofm_rd_fifo.sv - two-entry output FIFO for the OFM readout path
//
// Purpose : holds up to two read-back words while the consumer stalls.
// Ports   : clk, rst (async, active-high)
//           push, push_data - write one entry (ignored when full and not popping)
//           pop             - drop the head entry (ignored when empty)
//           head_data       - oldest entry (0 when empty after reset)
//           full, empty     - occupancy flags
module ofm_rd_fifo #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != 2'd0);
    // A full FIFO can still accept a word in the same cycle its head leaves.
    do_push = push && ((cnt_q != 2'd2) || do_pop);
    case (cnt_q)
      2'd0: begin
        if (do_push) begin
          head_d = push_data;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (do_push && do_pop) begin
          head_d = push_data;
        end else if (do_push) begin
          tail_d = push_data;
          cnt_d  = 2'd2;
        end else if (do_pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (do_pop) begin
          head_d = tail_q;
          if (do_push) begin
            tail_d = push_data;
          end else begin
            cnt_d = 2'd1;
          end
        end
      end
      default: cnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = head_q;
  assign full      = (cnt_q == 2'd2);
  assign empty     = (cnt_q == 2'd0);

endmodule

// File: rtl/ofm_read_controller.sv
// rtl/ofm_read_controller.sv - streams num_channel OFM planes out of the OFM buffer
//
// Purpose : on start, reads num_channel*OFM_SIZE*OFM_SIZE consecutive words
//           from base_addr (wrapping modulo 2^ADDR_WIDTH) and streams them out
//           with valid/ready flow control through a 2-entry FIFO.
// Ports   : clk, rst (async, active-high)
//           start, base_addr, num_channel - launch one readout (sampled in IDLE)
//           ofm_rd_en, ofm_rd_addr, ofm_rd_data - buffer read port, 1-cycle latency
//           data_out, data_valid, data_ready - output stream
//           busy, done - status; done pulses for one cycle after the last transfer
//           data_last - final word of each channel (only with OFM_READ_LAST_EN)
// Config  : define OFM_READ_LAST_EN to add the data_last output.
module ofm_read_controller
  import ofm_read_controller_pkg::*;
#(
  parameter int OFM_SIZE   = OFM_SIZE_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [6:0]            num_channel,
  output logic                  ofm_rd_en,
  output logic [ADDR_WIDTH-1:0] ofm_rd_addr,
  input  logic [DATA_WIDTH-1:0] ofm_rd_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  done
`ifdef OFM_READ_LAST_EN
  ,
  output logic                  data_last
`endif
);

  localparam logic [CNT_WIDTH-1:0] PIX_PER_CH = CNT_WIDTH'(OFM_SIZE * OFM_SIZE);

`ifdef OFM_READ_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif

  ofm_rd_state_e         state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_WIDTH-1:0]  xfer_cnt_q, xfer_cnt_d;
  logic                  inflight_q, inflight_d;
`ifdef OFM_READ_LAST_EN
  logic [CNT_WIDTH-1:0]  pix_q, pix_d;
  logic                  inflight_last_q, inflight_last_d;
`endif

  logic [CNT_WIDTH-1:0]  total_words;
  logic [1:0]            occ;
  logic                  rd_go;
  logic                  xfer;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]         word_in, fifo_head, out_word;

  assign total_words = CNT_WIDTH'(num_channel) * PIX_PER_CH;

  // Occupancy plus the outstanding read must stay below 2 so every returning
  // word has a slot even if the consumer stalls indefinitely.
  assign occ   = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign rd_go = (state_q == ST_READ) && (({1'b0, occ} + {2'b00, inflight_q}) < 3'd2);

`ifdef OFM_READ_LAST_EN
  assign word_in = {inflight_last_q, ofm_rd_data};
`else
  assign word_in = ofm_rd_data;
`endif

  // When the FIFO is empty the returning word is presented directly, which
  // gives the 2-cycle start-to-valid latency and 1 word/cycle streaming; it
  // only enters the FIFO if the consumer does not take it straight away.
  assign data_valid = !fifo_empty || inflight_q;
  assign xfer       = data_valid && data_ready;
  assign fifo_push  = inflight_q && !(fifo_empty && data_ready);
  assign fifo_pop   = !fifo_empty && data_ready;
  assign out_word   = !fifo_empty ? fifo_head : (inflight_q ? word_in : '0);

  assign data_out    = out_word[DATA_WIDTH-1:0];
`ifdef OFM_READ_LAST_EN
  assign data_last   = out_word[DATA_WIDTH];
`endif
  assign ofm_rd_en   = rd_go;
  assign ofm_rd_addr = addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);

  ofm_rd_fifo #(
    .WIDTH (FW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (word_in),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_cnt_d   = rd_cnt_q;
    xfer_cnt_d = xfer_cnt_q;
    inflight_d = rd_go;
`ifdef OFM_READ_LAST_EN
    pix_d           = pix_q;
    inflight_last_d = rd_go && (pix_q == PIX_PER_CH - CNT_WIDTH'(1));
`endif

    if (xfer) begin
      xfer_cnt_d = xfer_cnt_q - CNT_WIDTH'(1);
    end
    if (rd_go) begin
      addr_d   = addr_q + ADDR_WIDTH'(1);
      rd_cnt_d = rd_cnt_q - CNT_WIDTH'(1);
`ifdef OFM_READ_LAST_EN
      pix_d    = (pix_q == PIX_PER_CH - CNT_WIDTH'(1)) ? '0 : pix_q + CNT_WIDTH'(1);
`endif
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          rd_cnt_d   = total_words;
          xfer_cnt_d = total_words;
`ifdef OFM_READ_LAST_EN
          pix_d      = '0;
`endif
          state_d    = (num_channel == 7'd0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (rd_go && (rd_cnt_q == CNT_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (xfer && (xfer_cnt_q == CNT_WIDTH'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rd_cnt_q   <= '0;
      xfer_cnt_q <= '0;
      inflight_q <= 1'b0;
`ifdef OFM_READ_LAST_EN
      pix_q           <= '0;
      inflight_last_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_cnt_q   <= rd_cnt_d;
      xfer_cnt_q <= xfer_cnt_d;
      inflight_q <= inflight_d;
`ifdef OFM_READ_LAST_EN
      pix_q           <= pix_d;
      inflight_last_q <= inflight_last_d;
`endif
    end
  end

endmodule

// File: tb/tb_ofm_read_controller.sv
// tb/tb_ofm_read_controller.sv - self-checking bench for ofm_read_controller (OFM_READ_LAST_EN optional)
module tb_ofm_read_controller;

  localparam int OFM = 4;
  localparam int AW  = 14;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [6:0]    num_channel = '0;
  logic          ofm_rd_en;
  logic [AW-1:0] ofm_rd_addr;
  logic [DW-1:0] ofm_rd_data = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          data_ready = 1'b1;
  logic          busy;
  logic          done;
`ifdef OFM_READ_LAST_EN
  logic          data_last;
`endif

  ofm_read_controller #(
    .OFM_SIZE   (OFM),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .num_channel (num_channel),
    .ofm_rd_en   (ofm_rd_en),
    .ofm_rd_addr (ofm_rd_addr),
    .ofm_rd_data (ofm_rd_data),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .done        (done)
`ifdef OFM_READ_LAST_EN
    ,
    .data_last   (data_last)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return {2'b11, a} ^ 16'h0F0F;
  endfunction

  // Buffer model: one-cycle read latency.
  always @(posedge clk) begin
    if (ofm_rd_en) ofm_rd_data <= mem_f(ofm_rd_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},      ofm_rd_en,   0);
    check({tag, "_rd_addr"},    ofm_rd_addr, 0);
    check({tag, "_data_out"},   data_out,    0);
    check({tag, "_data_valid"}, data_valid,  0);
    check({tag, "_busy"},       busy,        0);
    check({tag, "_done"},       done,        0);
`ifdef OFM_READ_LAST_EN
    check({tag, "_data_last"},  data_last,   0);
`endif
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [6:0]    nch;
    bit            bp;
    bit            poke;
    int            exp_words;
    int            exp_first_lat;
    logic [AW-1:0] exp_last_addr;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int            nx, nrd, first_lat, done_cyc, last_xfer_cyc, nlast;
    logic [AW-1:0] last_rd_addr, tmp;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    int            exp_done;
    nx = 0; nrd = 0; first_lat = -1; done_cyc = -1; last_xfer_cyc = -1; nlast = 0;
    last_rd_addr = '0; prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    base_addr = v.base; num_channel = v.nch; start = 1'b1; data_ready = 1'b1;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.poke && cyc == 5) begin
        start = 1'b1; base_addr = v.base + AW'(1000); num_channel = 7'd5;
      end
      if (cyc == 1) check("busy_after_start", busy, 1);
      if (prev_stall) begin
        check("stall_valid", data_valid, 1);
        check("stall_data", data_out, prev_data);
      end
      if (data_valid && first_lat < 0) first_lat = cyc;
      if (ofm_rd_en) begin
        tmp = v.base + AW'(nrd);
        check("rd_addr", ofm_rd_addr, tmp);
        last_rd_addr = ofm_rd_addr;
        nrd++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      data_ready = v.bp ? ($urandom_range(0, 9) < 6) : 1'b1;
      if (data_valid && data_ready) begin
        tmp = v.base + AW'(nx);
        check("xfer_data", data_out, mem_f(tmp));
`ifdef OFM_READ_LAST_EN
        check("xfer_last", data_last, ((nx + 1) % (OFM * OFM)) == 0);
        if (data_last) nlast++;
`endif
        nx++;
        last_xfer_cyc = cyc;
      end
      prev_stall = data_valid && !data_ready;
      prev_data  = data_out;
    end
    start = 1'b0;
    data_ready = 1'b1;
    exp_done = (v.exp_words == 0) ? 1 : last_xfer_cyc + 1;
    check("words", nx, v.exp_words);
    check("reads", nrd, v.exp_words);
    check("first_valid_lat", first_lat, v.exp_first_lat);
    check("done_cycle", done_cyc, exp_done);
    if (v.exp_words > 0) check("last_rd_addr", last_rd_addr, v.exp_last_addr);
`ifdef OFM_READ_LAST_EN
    check("last_count", nlast, v.exp_words / (OFM * OFM));
`endif
    @(negedge clk);
    check("done_single", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  vec_t vecs[6];
  vec_t rv;
  int   nx_r;
  logic [AW-1:0] tmp_r;

  initial begin
    //           base   nch bp poke words lat last_addr
    vecs[0] = '{14'd100,   7'd2, 1'b0, 1'b0, 32,  2, 14'd131};
    vecs[1] = '{14'd100,   7'd2, 1'b1, 1'b0, 32,  2, 14'd131};
    vecs[2] = '{14'd16380, 7'd1, 1'b0, 1'b0, 16,  2, 14'd11};
    vecs[3] = '{14'd0,     7'd0, 1'b0, 1'b0, 0,  -1, 14'd0};
    vecs[4] = '{14'd200,   7'd1, 1'b1, 1'b1, 16,  2, 14'd215};
    vecs[5] = '{14'd7,     7'd3, 1'b0, 1'b0, 48,  2, 14'd54};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("post_reset");

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset in the middle of a readout, after 10 transfers.
    @(negedge clk);
    base_addr = 14'd100; num_channel = 7'd2; start = 1'b1; data_ready = 1'b1;
    nx_r = 0;
    for (int cyc = 1; cyc <= 100 && nx_r < 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (data_valid) begin
        tmp_r = 14'd100 + AW'(nx_r);
        check("pre_rst_data", data_out, mem_f(tmp_r));
        nx_r++;
      end
    end
    check("pre_rst_xfers", nx_r, 10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_rst");
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_no_done", done, 0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_idle", busy, 0);
    end
    rv = '{14'd500, 7'd1, 1'b0, 1'b0, 16, 2, 14'd515};
    run_vec(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
